// File: rtl/spu_mald_ctl.sv
// MA-load sequencer: fetches malen 64-bit words from L2 via the LSU and writes them into MA memory.
// Optional per-byte write parity is built when SPU_MALD_PARITY_EN is defined.
module spu_mald_ctl (
  input  logic        rclk,
  input  logic        arst_l,
  input  logic        se,
  input  logic        spu_mactl_iss_pulse_dly,
  input  logic        mactl_load,
  input  logic [7:0]  spu_mactl_malen,
  input  logic        spu_mactl_kill_op,
  input  logic        ldreq_ack,
  input  logic        ld_rtn_vld,
  input  logic [63:0] ld_rtn_data,
  input  logic        ld_rtn_err,
  output logic        spu_mald_ldreq,
  output logic        spu_mald_mpa_addrinc,
  output logic        spu_mald_memwen,
  output logic [63:0] spu_mald_memwdata,
  output logic [7:0]  spu_mald_memwpar,
  output logic        spu_mald_maaddr_addrinc,
  output logic        spu_mald_done_set,
  output logic        spu_mald_err_set
);

  // state    | meaning
  // IDLE     | no op in flight; waits for a qualified load issue
  // LDREQ    | load request raised to the LSU, waiting for ack
  // WAIT4RTN | request accepted, waiting for return data
  // MEMWR    | returned word written into MA memory this cycle
  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_LDREQ    = 4'b0010,
    ST_WAIT4RTN = 4'b0100,
    ST_MEMWR    = 4'b1000
  } state_t;

  state_t      r_state;
  logic [7:0]  r_rem;
  logic        r_ldreq;
  logic        r_mpa_addrinc;
  logic        r_memwen;
  logic [63:0] r_memwdata;
  logic        r_maaddr_addrinc;
  logic        r_done_set;
  logic        r_err_set;
  logic        w_issue;
  logic        w_kill;
  logic        w_unused_se;

  assign w_issue     = spu_mactl_iss_pulse_dly & mactl_load;
  assign w_kill      = spu_mactl_kill_op & (r_state != ST_IDLE);
  assign w_unused_se = se;

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_state          <= ST_IDLE;
      r_rem            <= 8'd0;
      r_ldreq          <= 1'b0;
      r_mpa_addrinc    <= 1'b0;
      r_memwen         <= 1'b0;
      r_memwdata       <= 64'd0;
      r_maaddr_addrinc <= 1'b0;
      r_done_set       <= 1'b0;
      r_err_set        <= 1'b0;
    end else begin
      r_ldreq          <= 1'b0;
      r_mpa_addrinc    <= 1'b0;
      r_memwen         <= 1'b0;
      r_maaddr_addrinc <= 1'b0;
      // Kill beats any same-cycle ack or return, so nothing below runs.
      if (w_kill) begin
        r_state    <= ST_IDLE;
        r_rem      <= 8'd0;
        r_done_set <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_issue) begin
              r_rem     <= spu_mactl_malen;
              r_err_set <= 1'b0;
              if (spu_mactl_malen == 8'd0) begin
                r_done_set <= 1'b1;
              end else begin
                r_done_set <= 1'b0;
                r_state    <= ST_LDREQ;
                r_ldreq    <= 1'b1;
              end
            end
          end
          ST_LDREQ: begin
            if (ldreq_ack) begin
              r_state       <= ST_WAIT4RTN;
              r_mpa_addrinc <= 1'b1;
            end else begin
              r_ldreq <= 1'b1;
            end
          end
          ST_WAIT4RTN: begin
            if (ld_rtn_vld) begin
              r_memwdata <= ld_rtn_data;
              if (ld_rtn_err) begin
                r_state    <= ST_IDLE;
                r_err_set  <= 1'b1;
                r_done_set <= 1'b1;
              end else begin
                r_state          <= ST_MEMWR;
                r_memwen         <= 1'b1;
                r_maaddr_addrinc <= 1'b1;
              end
            end
          end
          ST_MEMWR: begin
            r_rem <= r_rem - 8'd1;
            if (r_rem == 8'd1) begin
              r_state    <= ST_IDLE;
              r_done_set <= 1'b1;
            end else begin
              r_state <= ST_LDREQ;
              r_ldreq <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef SPU_MALD_PARITY_EN
  logic [7:0] r_memwpar;

  // Parity tracks the data register: updated on exactly the same returns.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_memwpar <= 8'd0;
    end else if (!w_kill && (r_state == ST_WAIT4RTN) && ld_rtn_vld) begin
      for (int i = 0; i < 8; i++) begin
        r_memwpar[i] <= ^ld_rtn_data[8*i +: 8];
      end
    end
  end

  assign spu_mald_memwpar = r_memwpar;
`else
  assign spu_mald_memwpar = 8'h00;
`endif

  assign spu_mald_ldreq          = r_ldreq;
  assign spu_mald_mpa_addrinc    = r_mpa_addrinc;
  assign spu_mald_memwen         = r_memwen;
  assign spu_mald_memwdata       = r_memwdata;
  assign spu_mald_maaddr_addrinc = r_maaddr_addrinc;
  assign spu_mald_done_set       = r_done_set;
  assign spu_mald_err_set        = r_err_set;

endmodule
